vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_VISIBLE, default 480: active lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BACK, default 33: vertical back porch, in lines.
REQ-009 vga_clk  input  1: pixel clock; the only clock.
REQ-010 reset  input  1: asynchronous, active-high reset.
REQ-011 DrawX  output  10: current pixel column, 0..H_TOTAL-1.
REQ-012 DrawY  output  10: current line, 0..V_TOTAL-1.
REQ-013 blank  output  1: display-enable, 1 = visible pixel; downstream pixel stages drive colour only when 1.
REQ-014 hs  output  1: horizontal sync, active low.
REQ-015 vs  output  1: vertical sync, active low.
REQ-016 frame_start  output  1: one-cycle pulse while DrawX=0 and DrawY=0.
REQ-017 frame_count  output  8: frame counter for sprite animation.

Function
REQ-018 H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default).
REQ-019 DrawX and DrawY are registers; every rising vga_clk edge increments DrawX.
REQ-020 When DrawX = H_TOTAL-1, DrawX wraps to 0 and DrawY increments on the same edge.
REQ-021 When DrawX = H_TOTAL-1 and DrawY = V_TOTAL-1, both counters wrap to 0 on the same edge.
REQ-022 blank, hs, vs and frame_start are registered outputs, computed from the next counter values, so each always describes the current DrawX/DrawY with zero skew.
REQ-023 blank = 1 when DrawX < H_VISIBLE and DrawY < V_VISIBLE; otherwise 0.
REQ-024 hs = 0 when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default); otherwise 1.
REQ-025 vs = 0 when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default); otherwise 1. vs is evaluated on line number only and is independent of DrawX.
REQ-026 frame_start = 1 for exactly the one cycle at (0,0) of each frame; otherwise 0.
REQ-027 Neither counter ever exceeds its TOTAL-1 value; there is no stall, enable or handshake, and the block free-runs.

Reset
REQ-028 While reset = 1, the outputs are: DrawX = H_TOTAL-1, DrawY = V_TOTAL-1, hs = 1, vs = 1, blank = 0, frame_start = 0, frame_count = 0.
REQ-029 The first rising edge after reset deasserts moves the block to (0,0) with blank = 1 and frame_start = 1.
REQ-030 Reset asserted mid-frame forces the REQ-028 values immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro VGA_FRAME_COUNT_EN, when defined, enables the counter: frame_count increments on every edge that enters (0,0), wrapping from 255 to 0, and reads 1 during the first frame after reset.
REQ-032 When VGA_FRAME_COUNT_EN is undefined, frame_count is tied to 0 and no counter register is built; all other behaviour is identical.

Structure
REQ-033 Package vga_timing_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL values and the 10-bit coordinate typedef.
REQ-034 Sub-module wrap_counter (width, modulus, enable, wrap flag out, asynchronous reset to a load value) is instantiated once for X and once for Y; the Y instance is enabled by the X wrap flag.

Verification
REQ-035 Release reset, then run 1 edge -> DrawX = 0, DrawY = 0, blank = 1, frame_start = 1, hs = 1, vs = 1.
REQ-036 Run one full line from (0,0) -> blank falls at DrawX = 640; hs is low for exactly 96 cycles, from DrawX = 656 to DrawX = 751.
REQ-037 Run one full frame -> exactly 420000 cycles, i.e. 800x525 (the sum of the default parameters), between consecutive frame_start pulses; vs is low for exactly 1600 cycles, on lines 490 and 491.
REQ-038 At (799,524), advance 1 edge -> (0,0) with frame_start = 1; with VGA_FRAME_COUNT_EN defined, frame_count advances by 1, and after 256 frames it has wrapped to its original value.
REQ-039 Assert reset asynchronously at (300,200) -> outputs take the REQ-028 values before the next edge; release -> behaviour matches REQ-035.
REQ-040 Build without VGA_FRAME_COUNT_EN and run 3 frames -> frame_count stays 0, and all other outputs are cycle-identical to the VGA_FRAME_COUNT_EN build.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, coordinate type and a window helper for the VGA
// timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Output bundle of the VGA timing generator. The generator drives it through
// the master modport; pixel pipelines consume it through the slave modport.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo counter with enable. Resets asynchronously to a load value, exposes
// the value it will take on the next edge, and flags the edge on which it
// wraps back to zero.
module wrap_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800,
  parameter int LOAD    = MODULUS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(LOAD);

  logic [WIDTH-1:0] r_count;

  assign o_wrap  = i_en && (r_count == LAST);
  assign o_count = r_count;

  // Next value: hold, step, or wrap to zero at the top of the range.
  always_comb begin
    o_next = r_count;
    if (i_en) begin
      o_next = (r_count == LAST) ? '0 : r_count + WIDTH'(1);
    end
  end

  // Count register, loaded immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= LOAD_VAL;
    end else begin
      r_count <= o_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Free-running X/Y scan counters plus blank,
// hsync, vsync and frame-start flags, all registered from the counters' next
// values so they line up with DrawX/DrawY on the same cycle.
// Optional feature: define VGA_FRAME_COUNT_EN to build an 8-bit frame counter;
// otherwise frame_count reads 0 and no register is built for it.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic         vga_clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t X_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t X_SYNC_BEG = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t X_SYNC_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t Y_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t Y_SYNC_BEG = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t Y_SYNC_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t w_x;
  coord_t w_y;
  coord_t w_x_next;
  coord_t w_y_next;
  logic   w_x_wrap;
  logic   w_y_wrap;

  logic   r_blank;
  logic   r_hs;
  logic   r_vs;
  logic   r_frame_start;

  wrap_counter #(
    .WIDTH   (COORD_W),
    .MODULUS (H_TOTAL)
  ) u_x_cnt (
    .clk     (vga_clk),
    .rst     (reset),
    .i_en    (1'b1),
    .o_count (w_x),
    .o_next  (w_x_next),
    .o_wrap  (w_x_wrap)
  );

  // Y only steps on the edge where X wraps, so its wrap flag marks frame entry.
  wrap_counter #(
    .WIDTH   (COORD_W),
    .MODULUS (V_TOTAL)
  ) u_y_cnt (
    .clk     (vga_clk),
    .rst     (reset),
    .i_en    (w_x_wrap),
    .o_count (w_y),
    .o_next  (w_y_next),
    .o_wrap  (w_y_wrap)
  );

  // Flags decoded from the next position so they match DrawX/DrawY exactly.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_blank       <= (w_x_next < X_VIS_END) && (w_y_next < Y_VIS_END);
      r_hs          <= !in_window(w_x_next, X_SYNC_BEG, X_SYNC_END);
      r_vs          <= !in_window(w_y_next, Y_SYNC_BEG, Y_SYNC_END);
      r_frame_start <= w_y_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  // Counts every entry into (0,0); wraps naturally at 8 bits.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= 8'd0;
    end else if (w_y_wrap) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign vga.frame_count = r_frame_count;
`else
  assign vga.frame_count = 8'd0;
`endif

  assign vga.DrawX       = w_x;
  assign vga.DrawY       = w_y;
  assign vga.blank       = r_blank;
  assign vga.hs          = r_hs;
  assign vga.vs          = r_vs;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-timing instance and a small-timing
// instance share clock and reset. Expected outputs come from a position model
// based on the number of edges since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  // Small instance timing: 15 x 9 = 135 cycles per frame.
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 5, S_VF = 1, S_VS = 2, S_VB = 1;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  longint k   = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  vga_timing_if if_def ();
  vga_timing_if if_sml ();

  vga_timing_gen u_def (
    .vga_clk (clk),
    .reset   (rst),
    .vga     (if_def)
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) u_sml (
    .vga_clk (clk),
    .reset   (rst),
    .vga     (if_sml)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs after kk edges since reset release (kk = 0 means in reset).
  function automatic exp_t model(input longint kk, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb);
    exp_t   e;
    longint ht, vt, idx, xx, yy;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (kk == 0) begin
      e.x = 10'(ht - 1); e.y = 10'(vt - 1);
      e.blank = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.fc = 8'd0;
    end else begin
      idx = (kk - 1) % (ht * vt);
      xx  = idx % ht;
      yy  = idx / ht;
      e.x = 10'(xx);
      e.y = 10'(yy);
      e.blank = (xx < hv) && (yy < vv);
      e.hs = !((xx >= hv + hf) && (xx < hv + hf + hsw));
      e.vs = !((yy >= vv + vf) && (yy < vv + vf + vsw));
      e.fs = (idx == 0);
`ifdef VGA_FRAME_COUNT_EN
      e.fc = 8'(((kk - 1) / (ht * vt) + 1) % 256);
`else
      e.fc = 8'd0;
`endif
    end
    return e;
  endfunction

  task automatic check_dut(input string tag, input exp_t e, input logic [9:0] x,
                           input logic [9:0] y, input logic b, input logic h,
                           input logic v, input logic f, input logic [7:0] fc);
    check({tag, " DrawX"}, longint'(x), longint'(e.x));
    check({tag, " DrawY"}, longint'(y), longint'(e.y));
    check({tag, " blank"}, longint'(b), longint'(e.blank));
    check({tag, " hs"}, longint'(h), longint'(e.hs));
    check({tag, " vs"}, longint'(v), longint'(e.vs));
    check({tag, " frame_start"}, longint'(f), longint'(e.fs));
    check({tag, " frame_count"}, longint'(fc), longint'(e.fc));
  endtask

  task automatic check_both(input longint kk);
    check_dut("def", model(kk, 640, 16, 96, 48, 480, 10, 2, 33),
              if_def.DrawX, if_def.DrawY, if_def.blank, if_def.hs, if_def.vs,
              if_def.frame_start, if_def.frame_count);
    check_dut("sml", model(kk, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB),
              if_sml.DrawX, if_sml.DrawY, if_sml.blank, if_sml.hs, if_sml.vs,
              if_sml.frame_start, if_sml.frame_count);
  endtask

  // Edge count since reset release; reset only changes well away from posedge.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check_both(rst ? 0 : k);
  end

  // Frame period and vsync width of the small instance.
  longint sm_cyc = 0;
  longint sm_vs_low = 0;
  bit     sm_have_fs = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sm_have_fs = 1'b0;
      sm_cyc     = 0;
      sm_vs_low  = 0;
    end else begin
      sm_cyc++;
      if (!if_sml.vs) sm_vs_low++;
      if (if_sml.frame_start) begin
        if (sm_have_fs) begin
          check("sml frame period", sm_cyc, 135);
          check("sml vs low cycles per frame", sm_vs_low, 30);
        end
        sm_have_fs = 1'b1;
        sm_cyc     = 0;
        sm_vs_low  = 0;
      end
    end
  end

  task automatic first_edge_checks();
    @(posedge clk);
    #1;
    check("first edge DrawX", longint'(if_def.DrawX), 0);
    check("first edge DrawY", longint'(if_def.DrawY), 0);
    check("first edge blank", longint'(if_def.blank), 1);
    check("first edge frame_start", longint'(if_def.frame_start), 1);
    check("first edge hs", longint'(if_def.hs), 1);
    check("first edge vs", longint'(if_def.vs), 1);
  endtask

  task automatic assert_reset_now();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_both(0);
  endtask

  task automatic release_reset(input int hold);
    repeat (hold) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int     blank_fall_x, hs_first, hs_last, hs_cnt, n_fs;
    logic [7:0] fc_a;
    bit     found;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset DrawX", longint'(if_def.DrawX), 799);
    check("reset DrawY", longint'(if_def.DrawY), 524);
    release_reset(0);
    first_edge_checks();

    // One full line of the default instance starting at DrawX = 0.
    blank_fall_x = -1; hs_first = -1; hs_last = -1; hs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (!if_def.blank && blank_fall_x < 0) blank_fall_x = int'(if_def.DrawX);
      if (!if_def.hs) begin
        if (hs_first < 0) hs_first = int'(if_def.DrawX);
        hs_last = int'(if_def.DrawX);
        hs_cnt++;
      end
      @(posedge clk);
      #1;
    end
    check("line blank falls at", blank_fall_x, 640);
    check("line hs low cycles", hs_cnt, 96);
    check("line hs first low x", hs_first, 656);
    check("line hs last low x", hs_last, 751);

    // Mid-line asynchronous reset at DrawX = 300.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk);
      #2;
      if (if_def.DrawX == 10'd300) found = 1'b1;
    end
    check("wait for DrawX 300", longint'(found), 1);
    rst = 1'b1;
    #1;
    check_both(0);
    release_reset(2);
    first_edge_checks();

    // Random reset pulses at random positions.
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 1500)) @(posedge clk);
      assert_reset_now();
      release_reset(int'($urandom_range(1, 3)));
    end

    // Final release, then 256 uninterrupted frames of the small instance.
    assert_reset_now();
    release_reset(1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (if_sml.frame_start) found = 1'b1;
    end
    check("wait for first frame_start", longint'(found), 1);
    fc_a = if_sml.frame_count;
`ifdef VGA_FRAME_COUNT_EN
    check("first frame count", longint'(fc_a), 1);
`else
    check("first frame count", longint'(fc_a), 0);
`endif
    n_fs = 0;
    for (int i = 0; i < 256 * 135 + 200 && n_fs < 256; i++) begin
      @(negedge clk);
      if (if_sml.frame_start) n_fs++;
    end
    check("frame_start pulses in 256 frames", n_fs, 256);
    check("frame_count after 256 frames", longint'(if_sml.frame_count), longint'(fc_a));

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
